// File: rtl/piso_tx_ctrl_pkg.sv
// Shared types and constants for the PISO transmit sequencer and its shift register.
package piso_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic SHIFT_MODE_LOAD  = 1'b0;
  localparam logic SHIFT_MODE_SHIFT = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load / shift-left register feeding the serial line; MSB is the line bit.
module piso_shreg
  import piso_tx_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             shift_mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en) begin
      if (shift_mode == SHIFT_MODE_SHIFT)
        q <= {q[WIDTH-2:0], 1'b0};
      else
        q <= d;
    end
  end

endmodule

// File: rtl/piso_tx_ctrl.sv
// Word-at-a-time serial transmitter: accepts a word, shifts it MSB-first on bit_tick,
// then idles the line for GAP_TICKS ticks before taking the next word.
module piso_tx_ctrl
  import piso_tx_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_tick,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             done,
  output logic             busy
);

  localparam int BW = clog2_min1(WIDTH);
  localparam int GW = clog2_min1(GAP_TICKS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             done_q;
  logic [WIDTH-1:0] shreg_q;
  logic             sh_en;
  logic             sh_mode;
  logic [WIDTH-1:0] sh_d;
  logic             accept;

  assign in_ready = (state == ST_IDLE) & ~rst;
  assign accept   = in_valid & in_ready & ~abort;

  // Abort reloads zero so a cancelled word never lingers in the datapath.
  always_comb begin
    sh_en   = 1'b0;
    sh_mode = SHIFT_MODE_LOAD;
    sh_d    = in_data;
    if (abort && state != ST_IDLE) begin
      sh_en = 1'b1;
      sh_d  = '0;
    end else if (state == ST_SHIFT && bit_tick) begin
      sh_en   = 1'b1;
      sh_mode = SHIFT_MODE_SHIFT;
    end else if (accept) begin
      sh_en = 1'b1;
    end
  end

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .en         (sh_en),
    .shift_mode (sh_mode),
    .d          (sh_d),
    .q          (shreg_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        gap_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_valid) begin
              state   <= ST_SHIFT;
              bit_cnt <= BIT_LAST;
            end
          end
          ST_SHIFT: begin
            if (bit_tick) begin
              if (bit_cnt != '0)
                bit_cnt <= bit_cnt - BW'(1);
              else begin
                done_q <= 1'b1;
                if (GAP_TICKS > 0) begin
                  state   <= ST_GAP;
                  gap_cnt <= GAP_INIT;
                end else
                  state <= ST_IDLE;
              end
            end
          end
          ST_GAP: begin
            if (bit_tick) begin
              if (gap_cnt == '0)
                state <= ST_IDLE;
              else
                gap_cnt <= gap_cnt - GW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ser_valid   = (state == ST_SHIFT);
  assign ser_out     = ser_valid & shreg_q[WIDTH-1];
  assign frame_start = ser_valid & (bit_cnt == BIT_LAST);
  assign frame_end   = ser_valid & (bit_cnt == '0);
  assign done        = done_q;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Bench for piso_tx_ctrl: directed scenarios on a GAP_TICKS=1 and a GAP_TICKS=0 instance,
// then random traffic against a bits-remaining reference model.
module tb_piso_tx_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data [2];
  logic [1:0]   in_valid, bit_tick, abort;
  wire  [1:0]   in_ready, ser_out, ser_valid, frame_start, frame_end, done, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(W), .GAP_TICKS(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .bit_tick(bit_tick[0]), .abort(abort[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .frame_start(frame_start[0]), .frame_end(frame_end[0]), .done(done[0]), .busy(busy[0])
  );

  piso_tx_ctrl #(.WIDTH(W), .GAP_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .bit_tick(bit_tick[1]), .abort(abort[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .frame_start(frame_start[1]), .frame_end(frame_end[1]), .done(done[1]), .busy(busy[1])
  );

  // Observed vector order: {ser_valid, ser_out, frame_start, frame_end, done, busy, in_ready}
  wire [6:0] obs0 = {ser_valid[0], ser_out[0], frame_start[0], frame_end[0], done[0], busy[0], in_ready[0]};
  wire [6:0] obs1 = {ser_valid[1], ser_out[1], frame_start[1], frame_end[1], done[1], busy[1], in_ready[1]};

  // Reference: a word is "bits remaining" plus "gap ticks remaining"; idle when both are zero.
  int           m_cnt [2];
  int           m_gap [2];
  logic [W-1:0] m_word[2];
  bit           m_done[2];

  always @(posedge clk) begin
    int c, g, gap_ticks;
    bit d;
    for (int i = 0; i < 2; i++) begin
      gap_ticks = (i == 0) ? 1 : 0;
      c = m_cnt[i];
      g = m_gap[i];
      d = 1'b0;
      if (rst || abort[i]) begin
        c = 0;
        g = 0;
      end else if (c > 0) begin
        if (bit_tick[i]) begin
          c = c - 1;
          if (c == 0) begin
            d = 1'b1;
            g = gap_ticks;
          end
        end
      end else if (g > 0) begin
        if (bit_tick[i]) g = g - 1;
      end else if (in_valid[i]) begin
        m_word[i] <= in_data[i];
        c = W;
      end
      m_cnt[i]  <= c;
      m_gap[i]  <= g;
      m_done[i] <= d;
    end
  end

  task automatic clear_inputs();
    in_valid = '0;
    bit_tick = '0;
    abort    = '0;
    in_data[0] = '0;
    in_data[1] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs0 !== 7'b0) begin n_err++; $display("FAIL reset inst0: got %b want %b", obs0, 7'b0); end
    n_cmp++;
    if (obs1 !== 7'b0) begin n_err++; $display("FAIL reset inst1: got %b want %b", obs1, 7'b0); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs0 !== 7'b0000001) begin n_err++; $display("FAIL reset_release inst0: got %b want %b", obs0, 7'b0000001); end
    n_cmp++;
    if (obs1 !== 7'b0000001) begin n_err++; $display("FAIL reset_release inst1: got %b want %b", obs1, 7'b0000001); end
  endtask

  task automatic test_basic();
    logic [W-1:0] w = 4'b1011;
    logic [6:0]   exp;
    @(negedge clk);
    in_data[0] = w; in_valid[0] = 1'b1; bit_tick[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      exp = {1'b1, w[W-1-k], (k == 0), (k == W-1), 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (obs0 !== exp) begin n_err++; $display("FAIL basic bit%0d: got %b want %b", k, obs0, exp); end
    end
    @(negedge clk);
    n_cmp++;
    if (obs0 !== 7'b0000110) begin n_err++; $display("FAIL basic done: got %b want %b", obs0, 7'b0000110); end
    @(negedge clk);
    n_cmp++;
    if (obs0 !== 7'b0000001) begin n_err++; $display("FAIL basic gap_end: got %b want %b", obs0, 7'b0000001); end
    bit_tick[0] = 1'b0;
  endtask

  task automatic test_slow_tick();
    logic [W-1:0] w = 4'b0110;
    logic [6:0]   exp;
    @(negedge clk);
    in_data[0] = w; in_valid[0] = 1'b1; bit_tick[0] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) in_valid[0] = 1'b0;
      if (c <= 12)      exp = {1'b1, w[W-1-(c-1)/3], (c <= 3), (c >= 10), 1'b0, 1'b1, 1'b0};
      else if (c == 13) exp = 7'b0000110;
      else if (c < 16)  exp = 7'b0000010;
      else              exp = 7'b0000001;
      n_cmp++;
      if (obs0 !== exp) begin n_err++; $display("FAIL slow_tick c%0d: got %b want %b", c, obs0, exp); end
      bit_tick[0] = (c % 3 == 0);
    end
    bit_tick[0] = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    in_data[0] = 4'b1111; in_valid[0] = 1'b1; bit_tick[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n_cmp++;
    if (obs0 !== 7'b1110010) begin n_err++; $display("FAIL abort bit0: got %b want %b", obs0, 7'b1110010); end
    @(negedge clk);
    n_cmp++;
    if (obs0 !== 7'b1100010) begin n_err++; $display("FAIL abort bit1: got %b want %b", obs0, 7'b1100010); end
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0; bit_tick[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (obs0 !== 7'b0000001) begin n_err++; $display("FAIL abort idle%0d: got %b want %b", k, obs0, 7'b0000001); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wa = 4'hA;
    logic [W-1:0] wb = 4'h5;
    logic [6:0]   exp;
    @(negedge clk);
    in_data[1] = wa; in_valid[1] = 1'b1; bit_tick[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 4)      exp = {1'b1, wa[W-c], (c == 1), (c == 4), 1'b0, 1'b1, 1'b0};
      else if (c == 5) exp = 7'b0000101;
      else if (c <= 9) exp = {1'b1, wb[W-(c-5)], (c == 6), (c == 9), 1'b0, 1'b1, 1'b0};
      else             exp = 7'b0000101;
      n_cmp++;
      if (obs1 !== exp) begin n_err++; $display("FAIL back_to_back c%0d: got %b want %b", c, obs1, exp); end
      if (c == 1) in_data[1] = wb;
      if (c == 6) in_valid[1] = 1'b0;
    end
    bit_tick[1] = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] w = 4'h9;
    logic [6:0]   exp;
    @(negedge clk);
    in_data[0] = 4'b1100; in_valid[0] = 1'b1; bit_tick[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n_cmp++;
    if (obs0 !== 7'b1110010) begin n_err++; $display("FAIL rst_mid pre: got %b want %b", obs0, 7'b1110010); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs0 !== 7'b0) begin n_err++; $display("FAIL rst_mid cleared: got %b want %b", obs0, 7'b0); end
    rst = 1'b0; in_data[0] = w; in_valid[0] = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (k == 0) in_valid[0] = 1'b0;
      exp = {1'b1, w[W-1-k], (k == 0), (k == W-1), 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (obs0 !== exp) begin n_err++; $display("FAIL rst_mid bit%0d: got %b want %b", k, obs0, exp); end
    end
    @(negedge clk);
    n_cmp++;
    if (obs0 !== 7'b0000110) begin n_err++; $display("FAIL rst_mid done: got %b want %b", obs0, 7'b0000110); end
    @(negedge clk);
    bit_tick[0] = 1'b0;
  endtask

  task automatic test_abort_idle();
    logic [W-1:0] w = W'($urandom);
    logic [6:0]   exp;
    int n = 0;
    @(negedge clk);
    in_data[0] = w; in_valid[0] = 1'b1; abort[0] = 1'b1; bit_tick[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs0 !== 7'b0000001) begin n_err++; $display("FAIL abort_idle blocked: got %b want %b", obs0, 7'b0000001); end
    abort[0] = 1'b0;
    @(negedge clk);
    exp = {1'b1, w[W-1], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (obs0 !== exp) begin n_err++; $display("FAIL abort_idle accept: got %b want %b", obs0, exp); end
    in_valid[0] = 1'b0; bit_tick[0] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[0] && n < 20);
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL abort_idle drain timeout: in_ready %b want 1", in_ready[0]); end
    bit_tick[0] = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] exp, obs;
    logic       eb;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        eb = 1'b0;
        if (m_cnt[i] > 0) eb = m_word[i][m_cnt[i]-1];
        exp = {(m_cnt[i] > 0), eb, (m_cnt[i] == W), (m_cnt[i] == 1), m_done[i],
               (m_cnt[i] > 0 || m_gap[i] > 0), (m_cnt[i] == 0 && m_gap[i] == 0 && !rst)};
        obs = (i == 0) ? obs0 : obs1;
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL random inst%0d cyc%0d: got %b want %b", i, cyc, obs, exp);
        end
      end
      rst = ($urandom_range(63) == 0);
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = 1'($urandom_range(1));
        bit_tick[i] = 1'($urandom_range(1));
        abort[i]    = ($urandom_range(15) == 0);
        in_data[i]  = W'($urandom);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_slow_tick();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    test_abort_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
